multicycle_control: RTL and testbench

- Multi-cycle sequencing controller for the MIPS-subset datapath: R-type, jr, lw, sw, beq, bne, addi, andi, ori, j, jal.
- Steps one instruction through fetch, decode, execute, memory and writeback states, using a shared ALU and one shared memory port.
- Sits beside the datapath. It receives op and funct from the instruction register, plus the ALU zero flag and the memory ready handshake.
- It drives every datapath mux select and write enable.

---
 rtl/multicycle_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for a MIPS-subset datapath.
// Steps each instruction through its state path and drives every datapath select and enable.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [2:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] SRCB_REG   = 3'b000;
    localparam logic [2:0] SRCB_FOUR  = 3'b001;
    localparam logic [2:0] SRCB_SEXT  = 3'b010;
    localparam logic [2:0] SRCB_SHIFT = 3'b011;
    localparam logic [2:0] SRCB_ZEXT  = 3'b100;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = STATE_W'(4'd0),
        S_DECODE    = STATE_W'(4'd1),
        S_MEM_ADDR  = STATE_W'(4'd2),
        S_MEM_READ  = STATE_W'(4'd3),
        S_MEM_WB    = STATE_W'(4'd4),
        S_MEM_WRITE = STATE_W'(4'd5),
        S_R_EXEC    = STATE_W'(4'd6),
        S_R_WB      = STATE_W'(4'd7),
        S_BRANCH    = STATE_W'(4'd8),
        S_I_EXEC    = STATE_W'(4'd9),
        S_I_WB      = STATE_W'(4'd10),
        S_JUMP      = STATE_W'(4'd11),
        S_JR        = STATE_W'(4'd12),
        S_TRAP      = STATE_W'(4'd13)
    } state_t;

    state_t state_q;
    state_t state_d;

    logic pc_write_s;
    logic ir_write_s;
    logic mem_read_s;
    logic mem_write_s;
    logic reg_write_s;
    logic instr_done_s;
    logic illegal_op_s;

    // Opcode dispatch out of DECODE; unknown opcodes park the controller in TRAP.
    function automatic state_t decode_next(input logic [5:0] op_v, input logic [5:0] funct_v);
        state_t nxt;
        case (op_v)
            OP_RTYPE:                nxt = (funct_v == FN_JR) ? S_JR : S_R_EXEC;
            OP_LW, OP_SW:            nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE:          nxt = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: nxt = S_I_EXEC;
            OP_J, OP_JAL:            nxt = S_JUMP;
            default:                 nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = decode_next(op, funct);
            S_MEM_ADDR:  state_d = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_JR:        state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls; everything not named in a state stays at zero.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        i_or_d       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        pc_source    = 2'b00;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_SHIFT;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                i_or_d     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg   = 2'b01;
                instr_done_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s  = 1'b1;
                i_or_d       = 1'b1;
                instr_done_s = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write_s  = 1'b1;
                reg_dst      = 2'b01;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_source    = 2'b01;
                instr_done_s = 1'b1;
                pc_write_s   = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                case (op)
                    OP_ANDI: begin
                        alu_src_b = SRCB_ZEXT;
                        alu_op    = ALU_AND;
                    end
                    OP_ORI: begin
                        alu_src_b = SRCB_ZEXT;
                        alu_op    = ALU_OR;
                    end
                    default: begin
                        alu_src_b = SRCB_SEXT;
                        alu_op    = ALU_ADD;
                    end
                endcase
            end
            S_I_WB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source    = 2'b10;
                instr_done_s = 1'b1;
                if (op == OP_JAL) begin
                    // PC already holds PC+4, which is the link value for $31.
                    reg_write_s = 1'b1;
                    reg_dst     = 2'b10;
                    mem_to_reg  = 2'b10;
                end else begin
                    reg_write_s = 1'b0;
                end
            end
            S_JR: begin
                pc_write_s   = 1'b1;
                pc_source    = 2'b11;
                instr_done_s = 1'b1;
            end
            S_TRAP: begin
                illegal_op_s = 1'b1;
            end
            default: begin
                illegal_op_s = 1'b0;
            end
        endcase
    end

    // Reset suppresses every enable and request immediately, not just at the next edge.
    assign pc_write   = pc_write_s   & ~rst;
    assign ir_write   = ir_write_s   & ~rst;
    assign mem_read   = mem_read_s   & ~rst;
    assign mem_write  = mem_write_s  & ~rst;
    assign reg_write  = reg_write_s  & ~rst;
    assign instr_done = instr_done_s & ~rst;
    assign illegal_op = illegal_op_s & ~rst;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases plus random instruction streams
// compared against a path-list model of each instruction class.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, pc_source;
    logic       alu_src_a;
    logic [2:0] alu_src_b, alu_op;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int path_q[$];

    logic [20:0] obs_s;
    assign obs_s = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected control word for a state, written straight from the per-state control table.
    function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] o, input logic z,
                                             input logic mr, input logic r);
        logic pcw, irw, iod, mrd, mwr, rw, asa, done, ill;
        logic [1:0] rd, m2r, pcs;
        logic [2:0] asb, aop;
        {pcw, irw, iod, mrd, mwr, rw, asa, done, ill} = 9'd0;
        {rd, m2r, pcs} = 6'd0;
        {asb, aop} = 6'd0;
        case (st)
            0:  begin mrd = 1'b1; asb = 3'b001; irw = mr; pcw = mr; end
            1:  asb = 3'b011;
            2:  begin asa = 1'b1; asb = 3'b010; end
            3:  begin mrd = 1'b1; iod = 1'b1; end
            4:  begin rw = 1'b1; m2r = 2'b01; done = 1'b1; end
            5:  begin mwr = 1'b1; iod = 1'b1; done = mr; end
            6:  begin asa = 1'b1; aop = 3'b010; end
            7:  begin rw = 1'b1; rd = 2'b01; done = 1'b1; end
            8:  begin
                    asa = 1'b1; aop = 3'b001; pcs = 2'b01; done = 1'b1;
                    pcw = ((o == 6'd4) && z) || ((o == 6'd5) && !z);
                end
            9:  begin
                    asa = 1'b1;
                    if (o == 6'b001000) asb = 3'b010;
                    if (o == 6'b001100) begin asb = 3'b100; aop = 3'b100; end
                    if (o == 6'b001101) begin asb = 3'b100; aop = 3'b011; end
                end
            10: begin rw = 1'b1; done = 1'b1; end
            11: begin
                    pcw = 1'b1; pcs = 2'b10; done = 1'b1;
                    if (o == 6'b000011) begin rw = 1'b1; rd = 2'b10; m2r = 2'b10; end
                end
            12: begin pcw = 1'b1; pcs = 2'b11; done = 1'b1; end
            13: ill = 1'b1;
            default: ill = 1'b0;
        endcase
        if (r) {pcw, irw, mrd, mwr, rw, done, ill} = 7'd0;
        return {pcw, irw, iod, mrd, mwr, rw, rd, m2r, asa, asb, aop, pcs, done, ill};
    endfunction

    // State path each instruction class walks, ignoring stalls.
    task automatic build_path(input logic [5:0] o, input logic [5:0] f);
        path_q = {0, 1};
        case (o)
            6'b000000: if (f == 6'b001000) path_q.push_back(12);
                       else begin path_q.push_back(6); path_q.push_back(7); end
            6'b100011: begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
            6'b101011: begin path_q.push_back(2); path_q.push_back(5); end
            6'b000100, 6'b000101: path_q.push_back(8);
            6'b001000, 6'b001100, 6'b001101: begin path_q.push_back(9); path_q.push_back(10); end
            6'b000010, 6'b000011: path_q.push_back(11);
            default: path_q.push_back(13);
        endcase
    endtask

    // zmode: 0/1 fixed zero flag, 2 random. stop_after > 0 aborts after that many cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fetch_pct,
                             input int data_stalls, input int zmode, input int stop_after);
        int idx, cyc, stalls, done_at, left, st;
        logic mr;
        build_path(o, f);
        op = o; funct = f;
        idx = 0; cyc = 0; stalls = 0; done_at = -1; left = data_stalls;
        while (idx < path_q.size() && cyc < 64 && !(stop_after > 0 && cyc >= stop_after)) begin
            st = path_q[idx];
            if (st == 0) mr = ($urandom_range(0, 99) >= fetch_pct);
            else if (st == 3 || st == 5) begin
                if (left > 0) begin mr = 1'b0; left--; end
                else mr = 1'b1;
            end else mr = 1'($urandom_range(0, 1));
            mem_ready = mr;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            #2;
            check("state", 32'(state), 32'(st));
            check("ctrl", 32'(obs_s), 32'(exp_ctrl(st, o, zero, mr, 1'b0)));
            cyc++;
            if (instr_done && done_at < 0) done_at = cyc;
            if ((st == 0 || st == 3 || st == 5) && !mr) stalls++;
            else idx++;
            @(posedge clk);
            #1;
        end
        if (stop_after == 0 && path_q[path_q.size()-1] != 13)
            check("latency", 32'(done_at), 32'(path_q.size() + stalls));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(obs_s), 32'(exp_ctrl(0, op, zero, mem_ready, 1'b1)));
        @(posedge clk);
        #1;
        check("rst_hold", 32'(state), 32'd0);
        rst = 1'b0;
    endtask

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                   6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b000011};

    initial begin
        rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #3;
        apply_reset();

        run_instr(6'b100011, 6'd0, 0, 0, 2, 0);        // lw, no stalls
        run_instr(6'b101011, 6'd0, 0, 2, 2, 0);        // sw, two MEM_WRITE stalls
        run_instr(6'b000100, 6'd0, 0, 0, 1, 0);        // beq taken
        run_instr(6'b000100, 6'd0, 0, 0, 0, 0);        // beq not taken
        run_instr(6'b000101, 6'd0, 0, 0, 0, 0);        // bne taken
        run_instr(6'b000101, 6'd0, 0, 0, 1, 0);        // bne not taken
        run_instr(6'b001101, 6'd0, 0, 0, 2, 0);        // ori
        run_instr(6'b001100, 6'd0, 0, 0, 2, 0);        // andi
        run_instr(6'b001000, 6'd0, 0, 0, 2, 0);        // addi
        run_instr(6'b000000, 6'b100000, 0, 0, 2, 0);   // add
        run_instr(6'b000011, 6'd0, 0, 0, 2, 0);        // jal
        run_instr(6'b000010, 6'd0, 0, 0, 2, 0);        // j
        run_instr(6'b000000, 6'b001000, 0, 0, 2, 0);   // jr
        run_instr(6'b100011, 6'd0, 50, 3, 2, 0);       // lw with fetch and data stalls

        for (int i = 0; i < 200; i++) begin
            logic [5:0] o, f;
            o = legal_ops[$urandom_range(0, 9)];
            f = ($urandom_range(0, 9) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
            run_instr(o, f, 25, $urandom_range(0, 3), 2, 0);
        end

        // Illegal opcode parks in TRAP until reset, whatever the inputs do.
        run_instr(6'b111111, 6'd0, 0, 0, 2, 0);
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #2;
            check("trap_state", 32'(state), 32'd13);
            check("trap_ctrl", 32'(obs_s), 32'(exp_ctrl(13, op, zero, mem_ready, 1'b0)));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("trap_rst_state", 32'(state), 32'd0);
        check("trap_rst_ctrl", 32'(obs_s), 32'(exp_ctrl(0, op, zero, mem_ready, 1'b1)));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset asserted while a load waits in MEM_READ.
        run_instr(6'b100011, 6'd0, 0, 0, 2, 3);
        mem_ready = 1'b0;
        #2;
        check("mrd_state", 32'(state), 32'd3);
        check("mrd_req", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check("mrd_rst_state", 32'(state), 32'd0);
        check("mrd_rst_req", 32'(mem_read), 32'd0);
        check("mrd_rst_ctrl", 32'(obs_s), 32'(exp_ctrl(0, op, zero, mem_ready, 1'b1)));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(6'b100011, 6'd0, 0, 1, 2, 0);        // recovery after reset
        run_instr(6'b010000, 6'd0, 0, 0, 2, 0);        // another unknown opcode
        apply_reset();
        run_instr(6'b101011, 6'd0, 30, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
